// File: rtl/udp_tx_framer_if.sv
// Byte-stream bundle for the UDP framer: payload input stream and datagram output stream.
// The framer takes the master modport (it masters the outgoing datagram stream).
interface udp_tx_framer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;

    modport master (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_valid, m_last
    );

    modport slave (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_valid, m_last
    );
endinterface

// File: rtl/udp_tx_framer.sv
// Buffered UDP datagram generator: stores one payload, then streams
// 8-byte header (runtime ports, computed length, zero checksum), payload and padding.
module udp_tx_framer #(
    parameter int unsigned MAX_PAYLOAD = 1472,
    parameter int unsigned MIN_PAYLOAD = 18,
    parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     src_port,
    input  logic [15:0]     dst_port,
    udp_tx_framer_if.master bus,
    output logic            busy,
    output logic            overflow
);
    localparam int unsigned CW = $clog2(MAX_PAYLOAD + 1);
    localparam int unsigned AW = $clog2(MAX_PAYLOAD);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_PAYLOAD);
    localparam logic [CW-1:0] MIN_C = CW'(MIN_PAYLOAD);

    typedef enum logic [2:0] {IDLE, DROP, HDR, PAY, PAD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   len_q, len_d;
    logic [15:0]     src_q, src_d, dst_q, dst_d;
    logic [7:0]      m_data_q, out_data;
    logic            m_valid_q, m_last_q, out_last, ld_out;
    logic            ovf_q, ovf_d, wr_en;
    logic [7:0]      mem [MAX_PAYLOAD];
    logic [7:0]      rd_data;
    logic [AW-1:0]   rd_addr;
    logic            s_rdy, s_fire, m_fire, ld, pend_last;
    logic [CW-1:0]   plen, npad;
    logic [15:0]     ulen;
    logic [7:0]      hdr_byte;

    assign s_rdy     = !rst && (state_q == IDLE || state_q == DROP);
    assign s_fire    = bus.s_valid && s_rdy;
    assign m_fire    = m_valid_q && bus.m_ready;
    assign ld        = !m_valid_q || bus.m_ready;
    assign pend_last = m_valid_q && m_last_q;

    assign plen = (len_q < MIN_C) ? MIN_C : len_q;
    assign npad = MIN_C - len_q;
    assign ulen = 16'd8 + 16'(plen);

    always_comb begin
        unique case (idx_q[2:0])
            3'd0:    hdr_byte = src_q[15:8];
            3'd1:    hdr_byte = src_q[7:0];
            3'd2:    hdr_byte = dst_q[15:8];
            3'd3:    hdr_byte = dst_q[7:0];
            3'd4:    hdr_byte = ulen[15:8];
            3'd5:    hdr_byte = ulen[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    // Header byte 0 is loaded on the s_last beat itself, straight from the port inputs,
    // so the datagram starts on the very next cycle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        count_d  = count_q;
        len_d    = len_q;
        src_d    = src_q;
        dst_d    = dst_q;
        ld_out   = 1'b0;
        out_data = m_data_q;
        out_last = 1'b0;
        ovf_d    = 1'b0;
        wr_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s_fire) begin
                    wr_en   = 1'b1;
                    count_d = count_q + CW'(1);
                    if (bus.s_last) begin
                        len_d    = count_q + CW'(1);
                        src_d    = src_port;
                        dst_d    = dst_port;
                        ld_out   = 1'b1;
                        out_data = src_port[15:8];
                        idx_d    = CW'(1);
                        state_d  = HDR;
                    end else if (count_q == MAX_C - CW'(1)) begin
                        len_d   = MAX_C;
                        ovf_d   = 1'b1;
                        state_d = DROP;
                    end
                end
            end
            DROP: begin
                if (s_fire && bus.s_last) begin
                    src_d    = src_port;
                    dst_d    = dst_port;
                    ld_out   = 1'b1;
                    out_data = src_port[15:8];
                    idx_d    = CW'(1);
                    state_d  = HDR;
                end
            end
            HDR: begin
                if (ld) begin
                    ld_out   = 1'b1;
                    out_data = hdr_byte;
                    if (idx_q == CW'(7)) begin
                        idx_d   = '0;
                        state_d = PAY;
                    end else begin
                        idx_d = idx_q + CW'(1);
                    end
                end
            end
            PAY: begin
                if (pend_last) begin
                    if (m_fire) begin
                        state_d = IDLE;
                        count_d = '0;
                    end
                end else if (ld) begin
                    ld_out   = 1'b1;
                    out_data = rd_data;
                    if (idx_q == len_q - CW'(1)) begin
                        idx_d = '0;
                        if (len_q < MIN_C) state_d = PAD;
                        else               out_last = 1'b1;
                    end else begin
                        idx_d = idx_q + CW'(1);
                    end
                end
            end
            PAD: begin
                if (pend_last) begin
                    if (m_fire) begin
                        state_d = IDLE;
                        count_d = '0;
                    end
                end else if (ld) begin
                    ld_out   = 1'b1;
                    out_data = PAD_BYTE;
                    if (idx_q == npad - CW'(1)) out_last = 1'b1;
                    else                        idx_d    = idx_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read address follows the next index so rd_data already holds the byte to load.
    assign rd_addr = idx_d[AW-1:0];

    always_ff @(posedge clk) begin
        if (wr_en) mem[count_q[AW-1:0]] <= bus.s_data;
        rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            count_q   <= '0;
            len_q     <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            len_q   <= len_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            ovf_q   <= ovf_d;
            if (ld_out) begin
                m_data_q  <= out_data;
                m_valid_q <= 1'b1;
                m_last_q  <= out_last;
            end else if (m_fire) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end
        end
    end

    assign bus.s_ready = s_rdy;
    assign bus.m_data  = m_data_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_last  = m_last_q;
    assign busy        = (state_q != IDLE) || (count_q != '0);
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_udp_tx_framer.sv
// Directed bench for udp_tx_framer (MAX_PAYLOAD=64) with hand-computed datagrams.
module tb_udp_tx_framer;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] src_port, dst_port;
    logic        busy, overflow;

    udp_tx_framer_if bus();

    udp_tx_framer #(.MAX_PAYLOAD(64), .MIN_PAYLOAD(18), .PAD_BYTE(8'h00)) dut (
        .clk(clk), .rst(rst), .src_port(src_port), .dst_port(dst_port),
        .bus(bus), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] got[$];
    logic [8:0] exp_q[$];
    logic [7:0] pay_q[$];
    int vcyc, beats, stalls, ovf_cnt, ovf_beat, bad, nl;
    bit lastpend, done;
    logic [7:0] prev_data;
    bit prev_stall = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Output monitor: records transfers and checks hold-stability under back-pressure.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                chk("hold_valid", 32'(bus.m_valid), 32'd1);
                chk("hold_data", 32'(bus.m_data), 32'(prev_data));
            end
            if (bus.m_valid && bus.m_ready) got.push_back({bus.m_last, bus.m_data});
            if (bus.m_valid) vcyc++;
            if (overflow) begin ovf_cnt++; ovf_beat = beats; end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send();
        for (int i = 0; i < pay_q.size(); i++) begin
            bus.s_data  = pay_q[i];
            bus.s_last  = (i == pay_q.size() - 1);
            bus.s_valid = 1'b1;
            for (int c = 0; c < 300; c++) begin
                if (bus.s_ready) break;
                stalls++;
                @(posedge clk); #1;
            end
            if (!bus.s_ready) chk("s_ready_timeout", 32'(bus.s_ready), 32'd1);
            @(posedge clk); #1;
            beats++;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input bit toggle);
        for (int c = 0; c < 400; c++) begin
            if (got.size() >= n) break;
            @(posedge clk); #1;
            if (toggle) bus.m_ready = ~bus.m_ready;
        end
        if (got.size() < n) chk("out_timeout", 32'(got.size()), 32'(n));
        bus.m_ready = 1'b1;
    endtask

    task automatic add_exp(input logic [15:0] s, input logic [15:0] d, input logic [15:0] ulen,
                           input int npay, input int npad);
        logic [8:0] t;
        exp_q.push_back({1'b0, s[15:8]});    exp_q.push_back({1'b0, s[7:0]});
        exp_q.push_back({1'b0, d[15:8]});    exp_q.push_back({1'b0, d[7:0]});
        exp_q.push_back({1'b0, ulen[15:8]}); exp_q.push_back({1'b0, ulen[7:0]});
        exp_q.push_back(9'h000);             exp_q.push_back(9'h000);
        for (int i = 0; i < npay; i++) exp_q.push_back({1'b0, pay_q[i]});
        for (int i = 0; i < npad; i++) exp_q.push_back(9'h000);
        t = exp_q.pop_back();
        t[8] = 1'b1;
        exp_q.push_back(t);
    endtask

    task automatic cmp_frame(input string tag);
        chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    endtask

    task automatic clear();
        got.delete(); exp_q.delete();
        vcyc = 0; beats = 0; stalls = 0; ovf_cnt = 0; ovf_beat = 0;
    endtask

    task automatic end_state(input string tag);
        chk({tag, "_s_ready"}, 32'(bus.s_ready), 32'd1);
        chk({tag, "_m_valid"}, 32'(bus.m_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; src_port = '0; dst_port = '0;
        bus.s_data = '0; bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.m_ready = 1'b1;
        clear();
        @(posedge clk); #1;
        chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
        @(posedge clk); #1;
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_m_last", 32'(bus.m_last), 32'd0);
        chk("rst_m_data", 32'(bus.m_data), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0; #1;
        chk("idle_s_ready", 32'(bus.s_ready), 32'd1);

        // Hello World, ports 5000/5001: ulen 26, 7 pad bytes
        clear();
        pay_q = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64};
        src_port = 16'd5000; dst_port = 16'd5001;
        send();
        chk("hello_lat_valid", 32'(bus.m_valid), 32'd1);
        chk("hello_lat_data", 32'(bus.m_data), 32'h13);
        chk("hello_s_ready_low", 32'(bus.s_ready), 32'd0);
        wait_bytes(26, 1'b0);
        add_exp(16'h1388, 16'h1389, 16'h001A, 11, 7);
        cmp_frame("hello");
        chk("hello_contig", 32'(vcyc), 32'd26);
        end_state("hello_end");

        // 40-byte ramp, no padding: ulen 0x30
        clear();
        pay_q.delete();
        for (int i = 0; i < 40; i++) pay_q.push_back(8'(i));
        src_port = 16'h1234; dst_port = 16'hABCD;
        send();
        wait_bytes(48, 1'b0);
        add_exp(16'h1234, 16'hABCD, 16'h0030, 40, 0);
        cmp_frame("ramp40");
        end_state("ramp40_end");

        // Hello World again under toggling m_ready
        clear();
        pay_q = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64};
        src_port = 16'd5000; dst_port = 16'd5001;
        send();
        wait_bytes(26, 1'b1);
        add_exp(16'h1388, 16'h1389, 16'h001A, 11, 7);
        cmp_frame("toggle");
        @(posedge clk); #1;
        end_state("toggle_end");

        // Overflow: 70 bytes into a 64-byte buffer
        clear();
        pay_q.delete();
        for (int i = 0; i < 70; i++) pay_q.push_back(8'(i) ^ 8'h5A);
        src_port = 16'h0102; dst_port = 16'h0304;
        send();
        chk("ovf_pulses", 32'(ovf_cnt), 32'd1);
        chk("ovf_beat", 32'(ovf_beat), 32'd64);
        chk("ovf_no_stall", 32'(stalls), 32'd0);
        wait_bytes(72, 1'b0);
        add_exp(16'h0102, 16'h0304, 16'h0048, 64, 0);
        cmp_frame("ovf");
        end_state("ovf_end");

        // Reset in the middle of a 40-byte payload
        clear();
        pay_q.delete();
        for (int i = 0; i < 40; i++) pay_q.push_back(8'(i));
        src_port = 16'h1234; dst_port = 16'hABCD;
        send();
        wait_bytes(12, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; #1;
        chk("midrst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_s_ready", 32'(bus.s_ready), 32'd1);
        nl = 0;
        foreach (got[i]) if (got[i][8]) nl++;
        chk("midrst_no_last", 32'(nl), 32'd0);
        clear();
        pay_q = '{8'hA5};
        src_port = 16'h0007; dst_port = 16'h0009;
        send();
        wait_bytes(26, 1'b0);
        add_exp(16'h0007, 16'h0009, 16'h001A, 1, 17);
        cmp_frame("postrst");
        end_state("postrst_end");

        // Back-to-back 1-byte frames with s_valid held high
        clear();
        src_port = 16'hAAAA; dst_port = 16'hBBBB;
        bus.s_data = 8'h11; bus.s_last = 1'b1; bus.s_valid = 1'b1;
        chk("bb_first_ready", 32'(bus.s_ready), 32'd1);
        @(posedge clk); #1;
        bus.s_data = 8'h22;
        src_port = 16'hCCCC; dst_port = 16'hDDDD;
        bad = 0; lastpend = 1'b0; done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (lastpend) begin
                chk("bb_s_ready_reopen", 32'(bus.s_ready), 32'd1);
                done = 1'b1;
                break;
            end
            if (bus.s_ready) bad++;
            lastpend = bus.m_valid && bus.m_ready && bus.m_last;
        end
        chk("bb_s_ready_low", 32'(bad), 32'd0);
        chk("bb_done", 32'(done), 32'd1);
        @(posedge clk); #1;
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
        chk("bb_second_lat_valid", 32'(bus.m_valid), 32'd1);
        chk("bb_second_lat_data", 32'(bus.m_data), 32'hCC);
        wait_bytes(52, 1'b0);
        pay_q = '{8'h11};
        add_exp(16'hAAAA, 16'hBBBB, 16'h001A, 1, 17);
        pay_q = '{8'h22};
        add_exp(16'hCCCC, 16'hDDDD, 16'h001A, 1, 17);
        cmp_frame("b2b");
        end_state("b2b_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
